// File: rtl/div_arb_pkg.sv
// Shared types and constants for the round-robin divider front end.
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DEF_M = 32;
    localparam int unsigned DEF_N = 4;

    // Width of a requester index; never zero so a 1-bit id port always exists.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module div_step #(
    parameter int unsigned M = 32
) (
    input  logic [M:0]   rem_i,
    input  logic         bit_i,
    input  logic [M-1:0] div_i,
    output logic [M:0]   rem_o,
    output logic         q_o
);

    logic [M:0] shifted;
    logic [M:0] diff;
    logic       fits;

    // rem_i[M] is zero while rem < divisor; a set top bit still implies shifted >= divisor.
    assign shifted = {rem_i[M-1:0], bit_i};
    assign diff    = shifted - {1'b0, div_i};
    assign fits    = rem_i[M] | (shifted >= {1'b0, div_i});

    assign rem_o = fits ? diff : shifted;
    assign q_o   = fits;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter in front of a shared M-cycle restoring divider.
// Optional statistics counters are enabled with macro DIV_ARB_STATS_EN.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned M = DEF_M,
    parameter int unsigned N = DEF_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    output logic [N-1:0]             req_ready,
    input  logic [N*M-1:0]           req_a,
    input  logic [N*M-1:0]           req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [id_width(N)-1:0]   rsp_id,
    output logic [M-1:0]             rsp_quotient,
    output logic [M-1:0]             rsp_remainder,
    output logic                     rsp_error
`ifdef DIV_ARB_STATS_EN
    ,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_errors
`endif
);

    localparam int unsigned IW = id_width(N);
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    div_state_e     state_q;
    logic [IW-1:0]  rr_ptr_q;
    logic [IW-1:0]  id_q;
    logic [M-1:0]   a_q;
    logic [M-1:0]   b_q;
    logic [M:0]     rem_q;
    logic [CW-1:0]  cnt_q;
    logic           rsp_valid_q;
    logic           rsp_error_q;
    logic [M-1:0]   quo_q;
    logic [M-1:0]   rmd_q;

    logic           grant_vld;
    logic [IW-1:0]  grant_idx;
    logic [IW-1:0]  rr_ptr_d;
    logic           accept;
    logic [M-1:0]   a_sel;
    logic [M-1:0]   b_sel;
    logic [M:0]     step_rem;
    logic           step_q;

    // First pending requester at or after rr_ptr, wrapping at N.
    always_comb begin
        int unsigned slot;
        logic [IW-1:0] slot_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        slot      = 0;
        slot_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            slot = 32'(rr_ptr_q) + i;
            if (slot >= N) begin
                slot = slot - N;
            end
            slot_idx = slot[IW-1:0];
            if (!grant_vld && req_valid[slot_idx]) begin
                grant_vld = 1'b1;
                grant_idx = slot_idx;
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && grant_vld;
    assign req_ready = accept ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign a_sel     = req_a[grant_idx*M +: M];
    assign b_sel     = req_b[grant_idx*M +: M];
    assign rr_ptr_d  = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

    div_step #(.M(M)) u_step (
        .rem_i (rem_q),
        .bit_i (a_q[M-1]),
        .div_i (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // a_q doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            quo_q       <= '0;
            rmd_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rr_ptr_q <= rr_ptr_d;
                        id_q     <= grant_idx;
                        if (b_sel == '0) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            quo_q       <= '0;
                            rmd_q       <= '0;
                        end else begin
                            state_q     <= ST_CALC;
                            a_q         <= a_sel;
                            b_q         <= b_sel;
                            rem_q       <= '0;
                            cnt_q       <= '0;
                            rsp_error_q <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    a_q   <= {a_q[M-2:0], step_q};
                    rem_q <= step_rem;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(M - 1)) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        quo_q       <= {a_q[M-2:0], step_q};
                        rmd_q       <= step_rem[M-1:0];
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rmd_q;

`ifdef DIV_ARB_STATS_EN
    logic [31:0] ops_q;
    logic [31:0] errs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q  <= '0;
            errs_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            ops_q  <= ops_q + 32'd1;
            errs_q <= errs_q + {31'd0, rsp_error_q};
        end
    end

    assign stat_ops    = ops_q;
    assign stat_errors = errs_q;
`endif

endmodule
